mcp3_arb_rr: RTL and testbench
==============================

# mcp3_arb_rr

Parametrised successor to the fixed 128-way request arbiter in the AFP command path. It selects one of `NUM_REQ` sticky request bits and registers the selection. The registered winner is held stable until the consumer takes it. It adds three things the fixed arbiter lacks:
- a high-priority request class with its own round-robin pointer;
- a run-time fixed-priority mode;
- back-to-back grants with self-masking of the request just taken.

## Interface
Parameters:
- `NUM_REQ`, default 128: number of requesters; power of 2, 4..256.
- `WIN_W`, default `$clog2(NUM_REQ)`: width of the encoded winner; derived, not overridden.

Ports:
- `clock`  in  1: the only clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_bus`  in  NUM_REQ: sticky request bits. A requester holds its bit until it sees its `req_clear` bit.
- `req_hipri`  in  NUM_REQ: per-requester high-priority qualifier. Meaningful only where the matching `req_bus` bit is 1.
- `mode_fixed`  in  1: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `req_taken`  in  1: consumer accepts the current winner this cycle.
- `final_valid`  out  1: registered; a winner is held.
- `final_winner`  out  WIN_W: registered; encoded index of the held winner.
- `req_clear`  out  NUM_REQ: combinational one-hot; equals `onehot(final_winner)` when `final_valid & req_taken`, else 0.
- `req_2pending`  out  1: combinational; `final_valid` and at least one eligible request other than the held winner.

## Operation
- Eligible set E = `req_bus & ~mask`.
  - `mask` = `onehot(final_winner)` in the cycle `req_taken` is accepted.
  - `mask` = 0 otherwise.
  - Purpose: the bit being cleared is never re-granted while the requester's register drops it.
- Class select:
  - If `E & req_hipri` is non-zero, candidates = `E & req_hipri` (HI class).
  - Otherwise candidates = E (LO class).
- Round-robin (`mode_fixed`=0):
  - Each class has its own pointer, `ptr_hi` and `ptr_lo`, each WIN_W bits, holding the last granted index of that class.
  - The search starts at `ptr+1` and wraps modulo `NUM_REQ`; the first candidate found wins.
  - On a load, only the winning class's pointer updates, to the new winner index. The other pointer holds.
- Fixed priority (`mode_fixed`=1):
  - The lowest-index candidate in the selected class wins. HI still beats LO.
  - Pointers do not update.
- Load condition: `(~final_valid | req_taken)` and candidates non-zero.
  - Then `final_valid` <= 1 and `final_winner` <= the selected index.
- If `(~final_valid | req_taken)` and candidates are zero, `final_valid` <= 0 and `final_winner` holds its old value.
- Hold: while `final_valid & ~req_taken`, `final_valid` and `final_winner` do not change. This holds even if the held winner's `req_bus` bit drops, or if higher-priority or HI requests arrive.
- `req_taken` while `final_valid`=0 is ignored: `req_clear` = 0 and no state changes.
- A `mode_fixed` change is applied at the next load only; it never alters a held winner.
- `req_2pending` = `final_valid` & |(`req_bus` & ~`onehot(final_winner)`). It is independent of class.

## Timing
- Reset (synchronous, wins over all other inputs):
  - `final_valid` = 0, `final_winner` = 0.
  - `ptr_hi` = `ptr_lo` = `NUM_REQ`-1, so index 0 is searched first.
  - `req_clear` = 0; `req_2pending` = 0.
- Reset mid-hold drops the winner without asserting `req_clear`. Requesters keep their bits and are re-arbitrated from index 0.
- Latency: a request rising in cycle t when idle gives `final_valid` = 1 in t+1.
- Take/regrant:
  - `req_taken` in cycle t produces `req_clear` in t (same cycle).
  - The next winner is valid in t+1: one grant per cycle at full throughput.
- Selection logic is a single-cycle combinational search; the registered outputs are `final_valid` and `final_winner` only.

## Test plan
- NUM_REQ=128, mode 0, after reset:
  - Stimulus: `req_bus` bits {5,70,127} set and held until cleared; `req_taken` tied 1.
  - Required: winners 5, 70, 127 on consecutive cycles; `req_clear` pulses `1<<5`, `1<<70`, `1<<127`; `final_valid` falls the cycle after 127 is taken.
- Hold:
  - Stimulus: winner 3 held with `req_taken`=0 for 10 cycles; request 1 with `req_hipri[1]`=1 arrives in cycle 2.
  - Required: `final_winner` stays 3 and `req_clear`=0 throughout; `req_2pending`=1 from cycle 2; the first take grants 1 next.
- HI/LO pointers:
  - Stimulus: requests {2 HI, 9 HI, 4 LO, 40 LO} held; taken every cycle.
  - Required: order 2, 9, 4, 40.
  - Then re-raise {2 HI, 4 LO}: required 2 then 4; `ptr_lo` is unaffected by the HI grants.
- Fixed mode:
  - Stimulus: `mode_fixed`=1, requests {0, 8} continuously re-raised after each clear.
  - Required: 0 wins every load; 8 starves; the pointers do not change.
- Self-mask:
  - Stimulus: single request 7 whose bit drops one cycle after `req_clear`; taken every cycle.
  - Required: exactly one `req_clear[7]` pulse and no re-grant of 7.
- Edges:
  - Stimulus: `req_taken`=1 while idle; then reset asserted while winner 12 is held.
  - Required: `req_clear` = 0 in both cases; outputs 0 the cycle after reset; after reset is released, 12 is re-granted.
- Parameter sweep: repeat the first scenario with NUM_REQ = 4, 16, 256 and check wrap from `NUM_REQ`-1 to 0.

Source files
------------

// File: rtl/mcp3_arb_rr.sv
// mcp3_arb_rr: registered NUM_REQ-way arbiter with separate HI/LO round-robin
// pointers, a fixed-priority mode, and self-masking of the request just taken.
//
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   req_bus           : sticky request bits, held until their req_clear bit
//   req_hipri         : per-requester high-priority qualifier
//   mode_fixed        : 0 = round-robin, 1 = lowest index wins
//   req_taken         : consumer accepts the held winner this cycle
//   final_valid       : registered, a winner is held
//   final_winner      : registered, encoded index of the held winner
//   req_clear         : one-hot clear of the winner being taken
//   req_2pending      : another request besides the held winner is pending
module mcp3_arb_rr #(
    parameter  int NUM_REQ = 128,
    localparam int WIN_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_bus,
    input  logic [NUM_REQ-1:0] req_hipri,
    input  logic               mode_fixed,
    input  logic               req_taken,
    output logic               final_valid,
    output logic [WIN_W-1:0]   final_winner,
    output logic [NUM_REQ-1:0] req_clear,
    output logic               req_2pending
);

    logic               r_valid;
    logic [WIN_W-1:0]   r_winner;
    logic [WIN_W-1:0]   r_ptr_hi;
    logic [WIN_W-1:0]   r_ptr_lo;

    logic [NUM_REQ-1:0] w_onehot;
    logic               w_take;
    logic               w_can_load;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_hi;
    logic               w_use_hi;
    logic [NUM_REQ-1:0] w_cand;
    logic [WIN_W-1:0]   w_ptr;
    logic [WIN_W-1:0]   w_start;
    logic [WIN_W-1:0]   w_idx;
    logic [WIN_W-1:0]   w_sel;
    logic               w_found;

    always_comb begin
        w_onehot           = '0;
        w_onehot[r_winner] = 1'b1;
    end

    assign w_take     = r_valid & req_taken;
    assign w_can_load = ~r_valid | req_taken;

    // The bit being cleared stays visible for this cycle; keep it out
    // so it cannot be granted back to back.
    assign w_elig   = req_bus & ~(w_take ? w_onehot : '0);
    assign w_hi     = w_elig & req_hipri;
    assign w_use_hi = |w_hi;
    assign w_cand   = w_use_hi ? w_hi : w_elig;
    assign w_ptr    = w_use_hi ? r_ptr_hi : r_ptr_lo;

    // Search from ptr+1 (or 0 in fixed mode); index arithmetic wraps
    // naturally because NUM_REQ is a power of two.
    always_comb begin
        w_start = mode_fixed ? '0 : w_ptr + WIN_W'(1);
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = w_start + WIN_W'(i);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_winner <= '0;
            r_ptr_hi <= WIN_W'(NUM_REQ - 1);
            r_ptr_lo <= WIN_W'(NUM_REQ - 1);
        end else if (w_can_load) begin
            if (w_found) begin
                r_valid  <= 1'b1;
                r_winner <= w_sel;
                if (!mode_fixed) begin
                    if (w_use_hi) begin
                        r_ptr_hi <= w_sel;
                    end else begin
                        r_ptr_lo <= w_sel;
                    end
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign final_valid  = r_valid;
    assign final_winner = r_winner;
    assign req_clear    = w_take ? w_onehot : '0;
    assign req_2pending = r_valid & (|(req_bus & ~w_onehot));

endmodule

// File: tb/tb_mcp3_arb_rr.sv
// tb_mcp3_arb_rr: directed scenarios for mcp3_arb_rr with a queue-based
// reference model checked every cycle, plus small-size wrap instances.
module tb_mcp3_arb_rr;

    localparam int N = 128;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req_bus = '0;
    logic [N-1:0] req_hipri = '0;
    logic         mode_fixed = 1'b0;
    logic         req_taken = 1'b0;
    logic         final_valid;
    logic [6:0]   final_winner;
    logic [N-1:0] req_clear;
    logic         req_2pending;

    logic [3:0]   b4 = '0;
    logic         v4;
    logic [1:0]   w4;
    logic [3:0]   c4;
    logic         p4;
    logic [15:0]  b16 = '0;
    logic         v16;
    logic [3:0]   w16;
    logic [15:0]  c16;
    logic         p16;

    always #5 clock = ~clock;

    mcp3_arb_rr #(.NUM_REQ(N)) dut (
        .clock(clock), .reset(reset), .req_bus(req_bus),
        .req_hipri(req_hipri), .mode_fixed(mode_fixed),
        .req_taken(req_taken), .final_valid(final_valid),
        .final_winner(final_winner), .req_clear(req_clear),
        .req_2pending(req_2pending)
    );

    mcp3_arb_rr #(.NUM_REQ(4)) dut4 (
        .clock(clock), .reset(reset), .req_bus(b4),
        .req_hipri(4'b0), .mode_fixed(1'b0), .req_taken(1'b1),
        .final_valid(v4), .final_winner(w4), .req_clear(c4),
        .req_2pending(p4)
    );

    mcp3_arb_rr #(.NUM_REQ(16)) dut16 (
        .clock(clock), .reset(reset), .req_bus(b16),
        .req_hipri(16'b0), .mode_fixed(1'b0), .req_taken(1'b1),
        .final_valid(v16), .final_winner(w16), .req_clear(c16),
        .req_2pending(p16)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Reference model: state, and the sequence of indices it granted.
    bit     chk_en = 1'b0;
    bit     m_valid = 1'b0;
    int     m_win = 0;
    int     m_phi = N - 1;
    int     m_plo = N - 1;
    int     grants[$];
    int     cq[$];
    logic [N-1:0] m_oh, m_el, m_hi, m_cand;
    bit     m_usehi;
    bit     m_hit;
    int     m_sel;
    int     m_p;

    // Inputs only change just after posedge, so at negedge they are the
    // values the next posedge will sample.
    always @(negedge clock) begin
        if (chk_en) begin
            m_oh = '0;
            m_oh[m_win] = 1'b1;
            chk("valid", N'(final_valid), N'(m_valid));
            chk("winner", N'(final_winner), N'(m_win));
            chk("clear", req_clear, (m_valid && req_taken) ? m_oh : '0);
            chk("2pend", N'(req_2pending),
                N'(m_valid && (|(req_bus & ~m_oh))));
            if (reset) begin
                m_valid = 1'b0;
                m_win   = 0;
                m_phi   = N - 1;
                m_plo   = N - 1;
            end else if (!m_valid || req_taken) begin
                m_el = req_bus;
                if (m_valid) m_el[m_win] = 1'b0;
                m_hi    = m_el & req_hipri;
                m_usehi = (m_hi != '0);
                m_cand  = m_usehi ? m_hi : m_el;
                cq = {};
                for (int k = 0; k < N; k++)
                    if (m_cand[k]) cq.push_back(k);
                if (cq.size() == 0) begin
                    m_valid = 1'b0;
                end else begin
                    m_sel = cq[0];
                    if (!mode_fixed) begin
                        m_p   = m_usehi ? m_phi : m_plo;
                        m_hit = 1'b0;
                        for (int j = 0; j < cq.size(); j++) begin
                            if (!m_hit && cq[j] > m_p) begin
                                m_hit = 1'b1;
                                m_sel = cq[j];
                            end
                        end
                        if (m_usehi) m_phi = m_sel;
                        else m_plo = m_sel;
                    end
                    m_valid = 1'b1;
                    m_win   = m_sel;
                    grants.push_back(m_sel);
                end
            end
        end
    end

    logic [N-1:0] cl;
    logic [3:0]   cl4;
    logic [15:0]  cl16;

    // Requesters drop their bit the cycle after they see req_clear.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            cl   = req_clear;
            cl4  = c4;
            cl16 = c16;
            @(posedge clock);
            #1;
            req_bus = req_bus & ~cl;
            b4      = b4 & ~cl4;
            b16     = b16 & ~cl16;
        end
    endtask

    task automatic chk_g(input string nm, input int n, input int a,
                         input int b, input int c, input int d);
        int e[4];
        e = '{a, b, c, d};
        chk({nm, "_cnt"}, N'(grants.size()), N'(n));
        for (int i = 0; i < n && i < grants.size(); i++)
            chk({nm, "_seq"}, N'(grants[i]), N'(e[i]));
        grants.delete();
    endtask

    task automatic set_bits(input int a, input int b, input int c,
                            input int d);
        if (a >= 0) req_bus[a] = 1'b1;
        if (b >= 0) req_bus[b] = 1'b1;
        if (c >= 0) req_bus[c] = 1'b1;
        if (d >= 0) req_bus[d] = 1'b1;
    endtask

    initial begin
        @(posedge clock);
        #1;
        chk_en = 1'b1;
        tick(1);
        chk("rst_valid", N'(final_valid), '0);
        chk("rst_2pend", N'(req_2pending), '0);
        reset = 1'b0;
        tick(1);

        // Basic round-robin drain.
        req_taken = 1'b1;
        set_bits(5, 70, 127, -1);
        tick(5);
        chk_g("rr", 3, 5, 70, 127, 0);
        chk("rr_idle", N'(final_valid), '0);

        // Hold with a late HI arrival.
        req_taken = 1'b0;
        set_bits(3, -1, -1, -1);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                req_bus[1]   = 1'b1;
                req_hipri[1] = 1'b1;
            end
            tick(1);
            chk("hold_win", N'(final_winner), N'(3));
            chk("hold_clr", req_clear, '0);
        end
        req_taken = 1'b1;
        tick(1);
        chk("hold_next", N'(final_winner), N'(1));
        tick(3);
        chk_g("hold", 2, 3, 1, 0, 0);
        req_hipri = '0;

        // Separate HI and LO pointers.
        req_hipri[2] = 1'b1;
        req_hipri[9] = 1'b1;
        set_bits(2, 9, 4, 40);
        tick(6);
        chk_g("hilo", 4, 2, 9, 4, 40);
        set_bits(2, 4, -1, -1);
        tick(4);
        chk_g("hilo2", 2, 2, 4, 0, 0);

        // Fixed priority, HI first; pointers left alone.
        mode_fixed = 1'b1;
        req_hipri  = '0;
        req_hipri[30] = 1'b1;
        set_bits(3, 8, 20, 30);
        tick(6);
        chk_g("fixed", 4, 30, 3, 8, 20);
        mode_fixed = 1'b0;
        req_hipri  = '0;
        set_bits(3, 5, -1, -1);
        tick(4);
        chk_g("ptrkeep", 2, 5, 3, 0, 0);

        // Self-mask: single request granted exactly once.
        set_bits(7, -1, -1, -1);
        tick(4);
        chk_g("mask", 1, 7, 0, 0, 0);

        // Take while idle, then reset mid-hold.
        tick(2);
        chk("idle_clr", req_clear, '0);
        req_taken = 1'b0;
        set_bits(12, -1, -1, -1);
        tick(2);
        chk("pre_rst", N'(final_winner), N'(12));
        reset = 1'b1;
        tick(1);
        chk("rst_v", N'(final_valid), '0);
        chk("rst_w", N'(final_winner), '0);
        chk("rst_c", req_clear, '0);
        reset = 1'b0;
        tick(1);
        chk("regrant", N'(final_winner), N'(12));
        chk_g("edge", 2, 12, 12, 0, 0);
        req_taken = 1'b1;
        tick(3);
        grants.delete();

        // Small sizes: full drain then wrap from NUM_REQ-1 to 0.
        b4  = 4'b1101;
        b16 = 16'h8101;
        tick(1);
        chk("s4_a", N'({v4, w4}), N'({1'b1, 2'd0}));
        chk("s16_a", N'({v16, w16}), N'({1'b1, 4'd0}));
        tick(1);
        chk("s4_b", N'({v4, w4}), N'({1'b1, 2'd2}));
        chk("s16_b", N'({v16, w16}), N'({1'b1, 4'd8}));
        tick(1);
        chk("s4_c", N'({v4, w4}), N'({1'b1, 2'd3}));
        chk("s16_c", N'({v16, w16}), N'({1'b1, 4'd15}));
        tick(1);
        chk("s4_idle", N'(v4), '0);
        chk("s16_idle", N'(v16), '0);
        b4  = 4'b0011;
        b16 = 16'h0003;
        tick(1);
        chk("s4_wrap", N'({v4, w4}), N'({1'b1, 2'd0}));
        chk("s16_wrap", N'({v16, w16}), N'({1'b1, 4'd0}));
        tick(1);
        chk("s4_d", N'({v4, w4}), N'({1'b1, 2'd1}));
        chk("s16_d", N'({v16, w16}), N'({1'b1, 4'd1}));
        chk("s4_2p", N'(p4), '0);
        chk("s16_2p", N'(p16), '0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
